// File: rtl/cpu7b_chk_pkg.sv
// Shared types for the retire-PC checkpoint monitor: FSM states, failure codes and the
// checkpoint entry layout (fields sized for the widest supported PC/data).
package cpu7b_chk_pkg;

    localparam int unsigned ChkPcMaxW   = 64;
    localparam int unsigned ChkDataMaxW = 64;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StCheck,
        StPass,
        StFail
    } chk_state_e;

    typedef enum logic [1:0] {
        FailNone     = 2'd0,
        FailMismatch = 2'd1,
        FailTimeout  = 2'd2
    } fail_code_e;

    typedef struct packed {
        logic [ChkPcMaxW-1:0]   pc;
        logic [4:0]             gpr;
        logic [ChkDataMaxW-1:0] exp;
        logic [ChkDataMaxW-1:0] mask;
    } chk_entry_t;

    // Only bits set in mask take part in the comparison.
    function automatic logic masked_match(input logic [ChkDataMaxW-1:0] obs,
                                          input logic [ChkDataMaxW-1:0] exp,
                                          input logic [ChkDataMaxW-1:0] mask);
        return ((obs ^ exp) & mask) == '0;
    endfunction

endpackage

// File: rtl/wb_chk_table.sv
// Checkpoint table: one synchronous write port, one asynchronous read port, cleared on reset.
module wb_chk_table
    import cpu7b_chk_pkg::*;
#(
    parameter int unsigned NUM_CHK = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  chk_entry_t       wdata,
    input  logic [IDX_W-1:0] raddr,
    output chk_entry_t       rdata
);

    chk_entry_t mem_q [NUM_CHK];
    chk_entry_t mem_d [NUM_CHK];

    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < NUM_CHK)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CHK; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Out-of-range indices (non power-of-two depth) read as an all-zero entry.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < NUM_CHK) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/wb_check_monitor.sv
// Retire-PC checkpoint monitor: waits for each programmed PC to retire, then compares one GPR
// against an expected value under mask and reports pass, mismatch or timeout.
module wb_check_monitor
    import cpu7b_chk_pkg::*;
#(
    parameter int unsigned NUM_CHK     = 4,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 100000,
    localparam int unsigned IDX_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
    localparam int unsigned NUM_W      = $clog2(NUM_CHK) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [PC_W-1:0]   cfg_pc,
    input  logic [4:0]        cfg_reg,
    input  logic [DATA_W-1:0] cfg_exp,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              start,
    input  logic [NUM_W-1:0]  start_num,
    input  logic              clear,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    output logic [4:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] obs_value
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);

    chk_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    fail_code_e        fail_code_q, fail_code_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [DATA_W-1:0] obs_q, obs_d;

    chk_entry_t cfg_entry;
    chk_entry_t cur_entry;
    logic       tbl_we;
    logic       pc_hit;
    logic       data_ok;
    logic       last_chk;
    logic       timeout_hit;
    logic [CNT_W-1:0] cnt_inc;

    assign tbl_we = cfg_we && (state_q == StIdle);

    always_comb begin
        cfg_entry      = '0;
        cfg_entry.pc   = ChkPcMaxW'(cfg_pc);
        cfg_entry.gpr  = cfg_reg;
        cfg_entry.exp  = ChkDataMaxW'(cfg_exp);
        cfg_entry.mask = ChkDataMaxW'(cfg_mask);
    end

    wb_chk_table #(
        .NUM_CHK (NUM_CHK),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (tbl_we),
        .waddr (cfg_idx),
        .wdata (cfg_entry),
        .raddr (ptr_q),
        .rdata (cur_entry)
    );

    assign pc_hit      = wb_valid && (ChkPcMaxW'(wb_pc) == cur_entry.pc);
    assign data_ok     = masked_match(ChkDataMaxW'(rf_rdata), cur_entry.exp, cur_entry.mask);
    assign last_chk    = (NUM_W'(ptr_q) + NUM_W'(1)) == num_q;
    assign timeout_hit = cnt_q >= CntLast;
    // Saturate so a late CHECK-to-RUN hand-off still sees the expired budget.
    assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        num_d       = num_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        fail_idx_d  = fail_idx_q;
        obs_d       = obs_q;

        if (clear) begin
            state_d     = StIdle;
            ptr_d       = '0;
            cnt_d       = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_code_d = FailNone;
            fail_idx_d  = '0;
            obs_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        num_d = start_num;
                        ptr_d = '0;
                        cnt_d = '0;
                        if (start_num == '0) begin
                            state_d = StPass;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d     = StFail;
                        done_d      = 1'b1;
                        fail_code_d = FailTimeout;
                        fail_idx_d  = ptr_q;
                    end else if (pc_hit) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    // The compare decision always wins over an expiring budget here.
                    cnt_d = cnt_inc;
                    obs_d = rf_rdata;
                    if (!data_ok) begin
                        state_d     = StFail;
                        done_d      = 1'b1;
                        fail_code_d = FailMismatch;
                        fail_idx_d  = ptr_q;
                    end else if (last_chk) begin
                        state_d = StPass;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = StRun;
                    end
                end
                StPass, StFail: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FailNone;
            fail_idx_q  <= '0;
            obs_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            num_q       <= num_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            fail_idx_q  <= fail_idx_d;
            obs_q       <= obs_d;
        end
    end

    assign rf_raddr  = (state_q == StCheck) ? cur_entry.gpr : 5'd0;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign fail_idx  = fail_idx_q;
    assign obs_value = obs_q;

endmodule
